// File: rtl/sample_arb_pkg.sv
// Shared types and helpers for the sample buffer read arbiter.
package sample_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

   localparam int unsigned REQ_MAD  = 0;
   localparam int unsigned REQ_DIST = 1;
   localparam int unsigned REQ_CHI  = 2;

   // burst and wait counters hold values up to 255
   localparam int unsigned CNT_W = 8;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin select: first set request after last_winner, with wrap-around.
module rr_picker #(
   parameter int unsigned NREQ  = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last_winner,
   output logic [NREQ-1:0]  winner_c,
   output logic             any_c
);

   always_comb begin
      int unsigned idx;
      winner_c = '0;
      any_c    = 1'b0;
      idx      = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = 32'(last_winner) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any_c && req[IDX_W'(idx)]) begin
            winner_c[IDX_W'(idx)] = 1'b1;
            any_c                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sample_rd_arbiter.sv
// Round-robin read arbiter/sequencer for the shared single-port sample buffer.
module sample_rd_arbiter
   import sample_arb_pkg::*;
#(
   parameter  int unsigned NREQ       = 3,
   parameter  int unsigned POPSIZE    = 100,
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned MAX_BURST  = 100,
   parameter  int unsigned TIMEOUT    = 255,
   localparam int unsigned ADDR_W     = addr_width(POPSIZE)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*ADDR_W-1:0] addr,
   output logic [NREQ-1:0]        gnt,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic [NREQ-1:0]        rd_vld,
   output logic [NREQ-1:0]        err,
   output logic                   mem_rd_rqst,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic                   mem_data_rdy,
   input  logic [DATA_WIDTH-1:0]  mem_data_in
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t              state, state_n;
   logic [NREQ-1:0]         gnt_n, rd_vld_n, err_n;
   logic [DATA_WIDTH-1:0]   rd_data_n;
   logic                    rqst_n;
   logic [ADDR_W-1:0]       mem_addr_n, owner_addr;
   logic [CNT_W-1:0]        burst_cnt, burst_n, wait_cnt, wait_n;
   logic [IDX_W-1:0]        last_winner, last_n, owner, owner_n, pick_idx;
   logic [NREQ-1:0]         pick;
   logic                    pick_any, release_gnt;

   rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
      .req         (req),
      .last_winner (last_winner),
      .winner_c    (pick),
      .any_c       (pick_any)
   );

   // one-hot winner to index, and the current owner's address slice
   always_comb begin
      pick_idx   = '0;
      owner_addr = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick[i]) pick_idx = IDX_W'(i);
         if (IDX_W'(i) == owner) owner_addr = addr[i*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      state_n     = state;
      gnt_n       = gnt;
      rd_data_n   = rd_data;
      rd_vld_n    = '0;
      err_n       = '0;
      rqst_n      = 1'b0;
      mem_addr_n  = mem_addr;
      burst_n     = burst_cnt;
      wait_n      = wait_cnt;
      last_n      = last_winner;
      owner_n     = owner;
      release_gnt = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               gnt_n   = pick;
               owner_n = pick_idx;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (32'(owner_addr) < POPSIZE) begin
               rqst_n     = 1'b1;
               mem_addr_n = owner_addr;
               wait_n     = '0;
               state_n    = WAIT;
            end else begin
               err_n[owner] = 1'b1;
               release_gnt  = 1'b1;
            end
         end
         WAIT: begin
            wait_n = wait_cnt + CNT_W'(1);
            if (mem_data_rdy) begin
               rd_data_n       = mem_data_in;
               rd_vld_n[owner] = 1'b1;
               burst_n         = burst_cnt + CNT_W'(1);
               state_n         = RESP;
            end else if (32'(wait_n) >= TIMEOUT) begin
               err_n[owner] = 1'b1;
               release_gnt  = 1'b1;
            end
         end
         RESP: begin
            if (req[owner] && 32'(burst_cnt) < MAX_BURST) state_n = ISSUE;
            else                                          release_gnt = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      // hand the buffer back and rotate priority past the releasing owner
      if (release_gnt) begin
         gnt_n   = '0;
         last_n  = owner;
         burst_n = '0;
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         gnt         <= '0;
         rd_data     <= '0;
         rd_vld      <= '0;
         err         <= '0;
         mem_rd_rqst <= 1'b0;
         mem_addr    <= '0;
         burst_cnt   <= '0;
         wait_cnt    <= '0;
         last_winner <= IDX_W'(NREQ - 1);
         owner       <= '0;
      end else begin
         state       <= state_n;
         gnt         <= gnt_n;
         rd_data     <= rd_data_n;
         rd_vld      <= rd_vld_n;
         err         <= err_n;
         mem_rd_rqst <= rqst_n;
         mem_addr    <= mem_addr_n;
         burst_cnt   <= burst_n;
         wait_cnt    <= wait_n;
         last_winner <= last_n;
         owner       <= owner_n;
      end
   end

endmodule
